// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter sharing one uart tx FIFO
// write port among NUM_REQ byte-stream requesters.
// Optional feature macro: UART_ARB_BURST_LIMIT_EN (forces rotation after
// MAX_BURST accepted bytes within one grant).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_write,
  input  logic                          tx_full,
  input  logic                          tx_almost_full,
  output logic                          busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH < 1 || MAX_BURST < 1) begin : g_cfg_err
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_write_q, tx_write_d;
  logic                  busy_q, busy_d;

  logic [PTR_W-1:0]      own_idx;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  space;
  logic                  accept;
  logic                  rel_grant;
  logic                  burst_hit;

  logic [NUM_REQ-1:0]    arb_grant;
  logic                  arb_any;
  int unsigned           arb_rel;
  int unsigned           best_rel;
  int unsigned           best_idx;

`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  logic [BURST_W-1:0] burst_q, burst_d;

  // An accept that would bring the count to MAX_BURST ends the grant
  assign burst_hit = ((burst_q + BURST_W'(1)) == BURST_W'(MAX_BURST));
`else
  assign burst_hit = 1'b0;
`endif

  // Owner decode, FIFO space and accept/release conditions
  always_comb begin
    own_idx   = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        own_idx   = PTR_W'(i);
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // The in-flight write already claims the last free slot
    space     = !tx_full && !(tx_write_q && tx_almost_full);
    accept    = (state_q == ST_XFER) && own_valid && space && !rst;
    rel_grant = accept && (own_last || burst_hit);
  end

  // Round-robin pick: smallest distance from the pointer among valid requesters
  always_comb begin
    arb_grant = '0;
    arb_any   = 1'b0;
    arb_rel   = 0;
    best_rel  = NUM_REQ;
    best_idx  = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      arb_rel = (j >= 32'(ptr_q)) ? (j - 32'(ptr_q)) : (j + NUM_REQ - 32'(ptr_q));
      if (req_valid[j] && (arb_rel < best_rel)) begin
        best_rel = arb_rel;
        best_idx = j;
        arb_any  = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      arb_grant[j] = arb_any && (best_idx == j);
    end
  end

  // State register and all output/datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      grant_q    <= '0;
      ptr_q      <= '0;
      tx_data_q  <= '0;
      tx_write_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_ARB_BURST_LIMIT_EN
      burst_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_write_q <= tx_write_d;
      busy_q     <= busy_d;
`ifdef UART_ARB_BURST_LIMIT_EN
      burst_q    <= burst_d;
`endif
    end
  end

  // Next-state: arbitrate when anyone is valid, return once the grant is released
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (arb_any) state_d = ST_XFER;
      ST_XFER: if (rel_grant) state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Outputs: grant capture, byte forwarding, pointer rotation on release
  always_comb begin
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    tx_write_d = 1'b0;
    req_ready  = '0;
`ifdef UART_ARB_BURST_LIMIT_EN
    burst_d    = burst_q;
`endif
    case (state_q)
      ST_ARB: begin
        grant_d = arb_grant;
`ifdef UART_ARB_BURST_LIMIT_EN
        burst_d = '0;
`endif
      end
      ST_XFER: begin
        req_ready = grant_q & {NUM_REQ{accept}};
        if (accept) begin
          tx_data_d  = own_data;
          tx_write_d = 1'b1;
`ifdef UART_ARB_BURST_LIMIT_EN
          burst_d    = burst_q + BURST_W'(1);
`endif
        end
        if (rel_grant) begin
          grant_d = '0;
          ptr_d   = (own_idx == PTR_W'(NUM_REQ - 1)) ? '0 : (own_idx + PTR_W'(1));
`ifdef UART_ARB_BURST_LIMIT_EN
          burst_d = '0;
`endif
        end
      end
      default: grant_d = '0;
    endcase
    busy_d = (|grant_d) || tx_write_d;
  end

  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_write = tx_write_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets per requester,
// expected bytes/grants queued at stimulus time, monitor checks tx writes.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    grant;
  logic [DW-1:0]         tx_data;
  logic                  tx_write;
  logic                  tx_full;
  logic                  tx_almost_full;
  logic                  busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .tx_data       (tx_data),
    .tx_write      (tx_write),
    .tx_full       (tx_full),
    .tx_almost_full(tx_almost_full),
    .busy          (busy)
  );

  int                 n_tests = 0;
  int                 n_fail  = 0;
  logic [8:0]         rq [NUM_REQ][$];   // {last, data} per requester
  logic [DW-1:0]      exp_q [$];
  logic [NUM_REQ-1:0] exp_g [$];
  int unsigned        wtime [$];
  int unsigned        cyc = 0;
  int unsigned        acc [NUM_REQ];
  logic [NUM_REQ-1:0] stall;
  logic [NUM_REQ-1:0] ready_s;
  logic [NUM_REQ-1:0] prev_grant = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // Present each requester's head byte unless stalled or empty
  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0 && !stall[i]) begin
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = rq[i][0][7:0];
        req_last[i]          = rq[i][0][8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  // One clock: drive, sample handshake before the edge, retire accepted bytes
  task automatic cycle();
    logic [8:0] dummy;
    drive();
    #1;
    ready_s = req_ready;
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    chk("ready_nonowner", 32'(req_ready & ~grant), 0);
    @(posedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && ready_s[i]) begin
        dummy = rq[i].pop_front();
        acc[i]++;
      end
    end
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    stall = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i].delete();
      acc[i] = 0;
    end
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((pending() || busy) && n < 300) begin
      cycle();
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(n < 300), 1);
    cycle();
    cycle();
    chk({name, "_bytes_left"}, exp_q.size(), 0);
    chk({name, "_grants_left"}, exp_g.size(), 0);
  endtask

  // Monitor: every FIFO write and every new grant is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_write) begin
        wtime.push_back(cyc);
        chk("write_while_full", 32'(tx_full), 0);
        chk("byte_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (grant != '0 && prev_grant == '0) begin
        chk("grant_expected", 32'(exp_g.size() > 0), 1);
        if (exp_g.size() > 0) chk("grant", 32'(grant), 32'(exp_g.pop_front()));
      end
      chk("grant_onehot", 32'($countones(grant) <= 1), 1);
    end
    prev_grant = grant;
  end

  initial begin
    int n;
    rst            = 1'b1;
    tx_full        = 1'b0;
    tx_almost_full = 1'b0;
    stall          = '0;
    req_valid      = '0;
    req_data       = '0;
    req_last       = '0;
    @(negedge clk);
    #2;

    // Reset values, then two 2-byte packets on requesters 0 and 2
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_tx_write", 32'(tx_write), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rq[0].push_back({1'b0, 8'hA1}); rq[0].push_back({1'b1, 8'hA2});
    rq[2].push_back({1'b0, 8'hC1}); rq[2].push_back({1'b1, 8'hC2});
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0100);
    wtime.delete();
    drain("t1");
    chk("t1_write_count", wtime.size(), 4);
    if (wtime.size() == 4) begin
      chk("t1_gap_a1_a2", wtime[1] - wtime[0], 1);
      chk("t1_gap_a2_c1", wtime[2] - wtime[1], 2);
      chk("t1_gap_c1_c2", wtime[3] - wtime[2], 1);
    end

    // All four valid with single-byte packets: rotation 0,1,2,3,0,1
    do_reset();
    rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h11});
    rq[1].push_back({1'b1, 8'h20}); rq[1].push_back({1'b1, 8'h21});
    rq[2].push_back({1'b1, 8'h30});
    rq[3].push_back({1'b1, 8'h40});
    exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h30);
    exp_q.push_back(8'h40); exp_q.push_back(8'h11); exp_q.push_back(8'h21);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010); exp_g.push_back(4'b0100);
    exp_g.push_back(4'b1000); exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
    drain("t2");

    // FIFO almost full with a write in flight, then full for 5 cycles
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rq[1].push_back({(k == 7), 8'(8'h50 + k)});
      exp_q.push_back(8'(8'h50 + k));
    end
    exp_g.push_back(4'b0010);
    n = 0;
    while (!tx_write && n < 20) begin
      cycle();
      n++;
    end
    chk("t3_stream_started", 32'(tx_write), 1);
    tx_almost_full = 1'b1;
    cycle();
    chk("t3_af_blocks_accept", 32'(ready_s), 0);
    tx_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_ready_while_full", 32'(ready_s), 0);
      chk("t3_no_write_while_full", 32'(tx_write), 0);
      chk("t3_grant_held", 32'(grant), 32'(4'b0010));
    end
    tx_full        = 1'b0;
    tx_almost_full = 1'b0;
    drain("t3");

    // Owner stalls mid-packet while requester 2 waits
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rq[0].push_back({(k == 3), 8'(8'h60 + k)});
      exp_q.push_back(8'(8'h60 + k));
    end
    rq[2].push_back({1'b1, 8'h70});
    exp_q.push_back(8'h70);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0100);
    n = 0;
    while (acc[0] < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("t4_two_accepted", acc[0], 2);
    stall[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t4_grant_held", 32'(grant), 32'(4'b0001));
      chk("t4_req2_blocked", 32'(ready_s[2]), 0);
    end
    chk("t4_req2_not_served", acc[2], 0);
    stall[0] = 1'b0;
    drain("t4");

    // Reset pulse on the third byte of a 6-byte packet
    do_reset();
    for (int k = 0; k < 6; k++) rq[2].push_back({(k == 5), 8'(8'h80 + k)});
    exp_q.push_back(8'h80); exp_q.push_back(8'h81);
    exp_g.push_back(4'b0100);
    n = 0;
    while (acc[2] < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("t5_two_accepted", acc[2], 2);
    rst = 1'b1;
    cycle();
    chk("t5_grant_after_rst", 32'(grant), 0);
    chk("t5_write_after_rst", 32'(tx_write), 0);
    chk("t5_byte3_not_taken", acc[2], 2);
    rst = 1'b0;
    rq[2].delete();
    rq[0].push_back({1'b1, 8'h90});
    rq[3].push_back({1'b1, 8'hA0});
    exp_q.push_back(8'h90); exp_q.push_back(8'hA0);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b1000);
    drain("t5");

    // Long packet against a single-byte packet (burst limit when enabled)
    do_reset();
    for (int k = 0; k < 10; k++) rq[0].push_back({(k == 9), 8'(8'hB0 + k)});
    rq[1].push_back({1'b1, 8'hC0});
`ifdef UART_ARB_BURST_LIMIT_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'hB0 + k));
    exp_q.push_back(8'hC0);
    for (int k = 4; k < 10; k++) exp_q.push_back(8'(8'hB0 + k));
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0001);
`else
    for (int k = 0; k < 10; k++) exp_q.push_back(8'(8'hB0 + k));
    exp_q.push_back(8'hC0);
    exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
`endif
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one uart transmit FIFO write port (tx_data / tx_write / tx_full / tx_almost_full) among NUM_REQ independent byte-stream requesters.
- Grants are packet-locked: once a requester wins, it owns the port until its byte flagged last is accepted.
- Sits between client logic (echo path, status reporter, debug console) and the uart top's tx ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; matches the uart data width.
- MAX_BURST, 16, bytes per grant before forced rotation; used only with UART_ARB_BURST_LIMIT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  byte is the final byte of its packet.
- req_ready  out  NUM_REQ  byte accepted this cycle (combinational, one-hot or zero).
- grant  out  NUM_REQ  registered one-hot current owner; 0 when idle.
- tx_data  out  DATA_WIDTH  registered byte to the tx FIFO.
- tx_write  out  1  registered single-cycle write strobe to the tx FIFO.
- tx_full  in  1  tx FIFO full.
- tx_almost_full  in  1  tx FIFO has at most one free entry.
- busy  out  1  grant held, or tx_write high.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous, active-high.
- Reset values: grant=0, tx_write=0, tx_data=0, busy=0, state=ARB, rr pointer=0 (requester 0 highest priority), burst counter=0.
- States:
  - ARB: if any req_valid, register the one-hot grant of the first valid requester at or after the pointer (wrapping modulo NUM_REQ), then go to XFER. Otherwise stay in ARB. No bytes are accepted in ARB.
  - XFER, space condition: space = !tx_full && !(tx_write && tx_almost_full). The in-flight write is counted against the single remaining slot.
  - XFER, accept: req_ready[g] = req_valid[g] && space. On accept, tx_data<=req_data[g] and tx_write<=1 next cycle; otherwise tx_write<=0.
  - XFER, end of packet: on accept with req_last[g], grant<=0, pointer<=g+1 (wrap at NUM_REQ), go to ARB.
- Latency and throughput:
  - Request to first accept: 1 bubble cycle (ARB).
  - Accept to tx_write: 1 cycle.
  - Peak rate is one byte per cycle while space holds.
  - Back-to-back packets cost one ARB cycle each.
- Owner stalls (req_valid low mid-packet): grant is held indefinitely and no other requester is serviced.
- Non-owner req_valid changes during XFER are ignored. Non-owners always see req_ready=0.
- FIFO full: req_ready=0, tx_write falls to 0 the next cycle, grant is held. The FIFO must never see a write while full.
- Simultaneous requests in ARB: the lowest index at or after the pointer wins. All requesters continuously valid yields the grant order 0,1,2,3,0...
- Single-byte packet (req_last on the first byte): XFER lasts exactly one accept cycle.
- Reset mid-packet:
  - Grant is dropped and tx_write is 0 in the cycle after rst is sampled high.
  - Bytes already written stay in the FIFO; the remainder of the packet is the requester's responsibility.
  - The pointer returns to 0.

Optional Feature:
- Macro: UART_ARB_BURST_LIMIT_EN.
- Defined:
  - A burst counter increments on each accept and clears on entering ARB.
  - When an accept brings the count to MAX_BURST without req_last, grant is released, the pointer advances past the owner, and the state returns to ARB, exactly as for a last byte.
  - The interrupted requester re-arbitrates for the remainder of its packet.
- Not defined: no counter is built, and grant is held strictly until req_last.

Test Plan:
- Reset release, req_valid=4'b0101, 2-byte packets on each (0xA1,0xA2 / 0xC1,0xC2) -> tx_write bytes in order A1,A2,C1,C2; grant 0001 then 0100; exactly one idle cycle between A2 and C1.
- All four requesters continuously valid with 1-byte packets -> grant order 0,1,2,3,0,1; no requester served twice before the others.
- tx_almost_full=1 while a write is in flight, tx_full asserted the next cycle for 5 cycles -> no tx_write while tx_full=1; req_ready=0 for those cycles; grant unchanged; transfer resumes with no byte lost or duplicated.
- Owner drops req_valid for 3 cycles mid-packet while requester 2 is valid -> grant stays on the owner; requester 2 sees req_ready=0 until the owner's last byte.
- rst pulsed for 1 cycle on the third byte of a 6-byte packet -> next cycle grant=0 and tx_write=0; then requester 0 wins the next arbitration.
- With UART_ARB_BURST_LIMIT_EN and MAX_BURST=4, requester 0 sends a 10-byte packet and requester 1 a 1-byte packet -> bytes 0-3, then requester 1's byte, then bytes 4-7, then 8-9. Without the macro -> all 10 bytes, then requester 1's byte.
